// File: rtl/data_memory_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_responder_pkg
// Shared types and constants for the data-memory responder slice.
//   state_e : responder FSM states (IDLE, BUSY, DONE)
//   CNT_W   : width of the latency down-counter (LATENCY up to 15)
//   WORD_W  : data word width
// ---------------------------------------------------------------------------
package data_memory_responder_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/data_memory_responder_if.sv
// ---------------------------------------------------------------------------
// data_memory_responder_if
// EX/MEM -> data-memory request bus plus the responder's return signals.
//   Memory_read_i  : load request
//   Memory_write_i : store request
//   addr_i         : byte address (ALU result)
//   data_i         : store data
//   data_o         : load data to MEM/WB
//   stall_o        : pipeline freeze request
//   err_o          : sticky protocol-error flag
// master = pipeline side, slave = responder side.
// ---------------------------------------------------------------------------
interface data_memory_responder_if;
    import data_memory_responder_pkg::*;

    logic              Memory_read_i;
    logic              Memory_write_i;
    logic [WORD_W-1:0] addr_i;
    logic [WORD_W-1:0] data_i;
    logic [WORD_W-1:0] data_o;
    logic              stall_o;
    logic              err_o;

    modport master (
        output Memory_read_i, Memory_write_i, addr_i, data_i,
        input  data_o, stall_o, err_o
    );

    modport slave (
        input  Memory_read_i, Memory_write_i, addr_i, data_i,
        output data_o, stall_o, err_o
    );

endinterface

// File: rtl/data_memory_responder_array.sv
// ---------------------------------------------------------------------------
// data_memory_array
// Single-port synchronous RAM, no reset. Read-first: rdata_o shows the word
// at idx_i as it was before any write on the same edge.
//   clk_i   : clock, rising edge
//   we_i    : write enable
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : registered read data
// ---------------------------------------------------------------------------
module data_memory_array
    import data_memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
        rdata_q <= mem[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
// Data-memory responder behind the EX/MEM register. Captures a load/store,
// spends LATENCY cycles in BUSY, performs the access on the last BUSY cycle,
// then presents one DONE cycle with stall released so the pipeline advances
// exactly once per access.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : request/response bus (slave side)
// ---------------------------------------------------------------------------
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    data_memory_responder_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req;
    logic              stall;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic [WORD_W-1:0] mem_rdata;
    logic              unused_addr_hi;

    assign req            = bus.Memory_read_i | bus.Memory_write_i;
    assign unused_addr_hi = ^bus.addr_i[WORD_W-1:ADDR_W+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        mem_idx = idx_q;
        stall   = 1'b0;

        case (state_q)
            IDLE: begin
                // Present the incoming index to the RAM so its registered
                // read port already holds the word once BUSY starts.
                mem_idx = bus.addr_i[ADDR_W+1:2];
                if (req) begin
                    stall   = 1'b1;
                    wr_d    = bus.Memory_write_i;
                    idx_d   = bus.addr_i[ADDR_W+1:2];
                    wdata_d = bus.data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                    if ((bus.Memory_read_i & bus.Memory_write_i) ||
                        (bus.addr_i[1:0] != 2'b00)) begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // The pipeline still presents the request just served.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    data_memory_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (mem_idx),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    assign bus.data_o  = rdata_q;
    assign bus.stall_o = stall;
    assign bus.err_o   = err_q;

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Data-memory responder at the far end of the EX/MEM boundary of the 5-stage pipeline.
- Accepts the memory-stage read/write controls, address and store data from the EX/MEM register.
- Performs the access with configurable multi-cycle latency and returns load data.
- Drives a stall to the hazard unit so the pipeline freezes until the access completes.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two.
- ADDR_W, 8, word-index width; equals log2(DEPTH_WORDS).
- LATENCY, 2, cycles spent in BUSY per access; legal range 1 to 15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- Memory_read_i  in  1  load request from the EX/MEM register.
- Memory_write_i  in  1  store request from the EX/MEM register.
- addr_i  in  32  byte address (ALU result).
- data_i  in  32  store data.
- data_o  out  32  load data to the MEM/WB register.
- stall_o  out  1  freeze request to the hazard unit and to all pipeline registers.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_i low, async):
  - state=IDLE, counter=0, data_o=0, err_o=0, stall_o=0.
  - Memory array not cleared.
  - Reset during BUSY aborts the access; a pending store is not committed.
- Word index = addr_i[ADDR_W+1:2]. Higher bits are ignored, so accesses wrap modulo DEPTH_WORDS.
- FSM states IDLE, BUSY, DONE:
  - IDLE: req = Memory_read_i | Memory_write_i. If req, capture op, index and data_i into internal registers, load counter=LATENCY-1, go to BUSY. Otherwise stay.
  - BUSY: if counter==0, perform the access and go to DONE; else decrement counter.
    - Store: mem[index] <= captured data.
    - Load: data_o <= mem[index].
  - DONE: unconditionally go to IDLE. Inputs are ignored here, because the pipeline still presents the request that was just served.
- stall_o (combinational) = (IDLE & req) | BUSY. stall_o is 0 in DONE, so the pipeline advances exactly once per access.
- Access latency: request seen in IDLE at cycle T; data_o valid and stall_o low at cycle T+LATENCY+1. The next request can be accepted at T+LATENCY+2.
- data_o holds its value until the next load completes. Stores never change data_o.
- Both Memory_read_i and Memory_write_i high in IDLE: treated as a store; err_o set.
- addr_i[1:0] != 0 on an accepted request: access uses the aligned word; err_o set.
- err_o is cleared only by reset.
- Back-to-back load after store to the same address returns the stored value; no bypass is needed because the store commits before DONE.

Decomposition:
- Shared package holds:
  - state enum (IDLE, BUSY, DONE);
  - the LATENCY counter width constant (4);
  - the word-size constant (32).
- One natural sub-module: data_memory_array, a single-port synchronous RAM with write-enable, index and 32-bit data, and no reset.
- The FSM, capture registers, stall and error logic stay in the top module.

Test Plan:
- Reset then idle: rst_i low 3 cycles, then high with no requests -> data_o=0, stall_o=0, err_o=0 throughout.
- Store then load, LATENCY=2:
  - Memory_write_i=1, addr_i=0x10, data_i=0xDEADBEEF -> stall_o high 3 cycles, low on 4th.
  - Then Memory_read_i=1, addr_i=0x10 -> data_o=0xDEADBEEF at T+3, stall_o low that cycle.
- Wrap-around, DEPTH_WORDS=256: store 0x12345678 to addr 0x400, load addr 0x000 -> data_o=0x12345678; err_o stays 0.
- Error cases:
  - Both requests high, addr 0x20, data 0xA5A5A5A5 -> word 8 written, err_o=1.
  - Subsequent load at addr 0x22 -> data_o=0xA5A5A5A5, err_o remains 1.
- Reset mid-access: memory preloaded with 0x11111111 at addr 0x30; start store of 0xFFFFFFFF to 0x30 and drop rst_i during BUSY -> state IDLE, stall_o=0 immediately; a later load of 0x30 returns 0x11111111.
- LATENCY=1 back-to-back loads held by a stalled pipeline -> each access is served once only, with exactly one DONE cycle between consecutive stall windows.
